// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: small TX FIFO, programmable bit period,
// 8N1 framing with back-to-back frames and an idle/empty interrupt level.
module uart_tx_mmio #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nx;
    logic            r_ovf;
    logic [15:0]     r_div;
    logic [15:0]     r_period;
    logic [15:0]     r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_irq;

    logic            w_sel_txdata;
    logic            w_sel_status;
    logic            w_sel_div;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_bit_end;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic [4:0]      w_count5;
    logic            w_unused_bits;

    assign w_sel_txdata  = wr_en && (addr[3:2] == 2'd0);
    assign w_sel_status  = wr_en && (addr[3:2] == 2'd1);
    assign w_sel_div     = wr_en && (addr[3:2] == 2'd2);
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_empty       = (r_count == CW'(0));
    assign w_busy        = (r_state != S_IDLE);
    assign w_bit_end     = (r_cnt == (r_period - 16'd1));
    assign w_count5      = 5'(r_count);
    assign w_unused_bits = ^{addr[1:0], wdata[31:16]};

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign w_push     = w_sel_txdata && (!w_full || w_pop);
    assign w_ovf_set  = w_sel_txdata && w_full && !w_pop;
    assign w_ovf_clr  = w_sel_status && wdata[3];
    assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

    // Next-state logic; the FIFO head is popped on every edge that enters START.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nx = S_START;
                    w_pop      = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                end else begin
                    w_state_nx = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_state_nx = S_STOP;
                end else begin
                    w_state_nx = S_DATA;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_state_nx = S_START;
                        w_pop      = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_state_nx = S_STOP;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_pop      = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FIFO, control registers, bit timing and registered line/interrupt outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_div    <= DIV_RESET;
            r_period <= DIV_RESET;
            r_cnt    <= 16'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
            r_irq    <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata[7:0];
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nx;

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_sel_div) begin
                r_div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end

            // The bit period is frozen per frame so divisor writes only affect later frames.
            if (w_pop) begin
                r_period <= r_div;
                r_shift  <= r_mem[r_rptr];
                r_cnt    <= 16'd0;
                r_bit    <= 3'd0;
                r_tx     <= 1'b0;
            end else if (w_busy) begin
                if (w_bit_end) begin
                    r_cnt <= 16'd0;
                    case (r_state)
                        S_START: r_tx <= r_shift[0];
                        S_DATA: begin
                            if (r_bit == 3'd7) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                            end
                        end
                        S_STOP:  r_tx <= 1'b1;
                        default: r_tx <= 1'b1;
                    endcase
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            r_irq <= (w_state_nx == S_IDLE) && (w_count_nx == CW'(0));
        end
    end

    // Load data decode; zero whenever no load is in progress.
    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (addr[3:2])
                2'd1:    rdata = {23'd0, w_count5, r_ovf, w_empty, w_full, w_busy};
                2'd2:    rdata = {16'd0, r_div};
                default: rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    assign tx  = r_tx;
    assign irq = r_irq;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random traffic,
// compared every cycle against a frame-timeline reference model.
module tb_uart_tx_mmio;

    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic [3:0]  addr  = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd4)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: a frame is (start edge, period, byte); the line level at
    // any cycle follows from the elapsed time divided by the period.
    bit         m_busy;
    int         m_t0;
    int         m_p;
    logic [7:0] m_byte;
    logic [7:0] m_q[$];
    int         m_div;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_busy = 1'b0;
        m_q.delete();
        m_div  = 4;
        m_ovf  = 1'b0;
    endfunction

    function automatic void m_edge();
        bit set_o;
        bit clr_o;
        set_o = 1'b0;
        clr_o = 1'b0;
        if (m_busy && (cyc == m_t0 + 10 * m_p)) m_busy = 1'b0;
        if (!m_busy && (m_q.size() > 0)) begin
            m_busy = 1'b1;
            m_t0   = cyc;
            m_p    = m_div;
            m_byte = m_q.pop_front();
        end
        if (wr_en) begin
            case (addr[3:2])
                2'd0: begin
                    if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
                    else set_o = 1'b1;
                end
                2'd1: clr_o = wdata[3];
                2'd2: m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
                default: ;
            endcase
        end
        if (set_o) m_ovf = 1'b1;
        else if (clr_o) m_ovf = 1'b0;
    endfunction

    function automatic logic m_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = (cyc - m_t0) / m_p;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        logic b_empty;
        logic b_full;
        b_empty = (m_q.size() == 0);
        b_full  = (m_q.size() == DEPTH);
        return {23'd0, 5'(m_q.size()), m_ovf, b_empty, b_full, m_busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) m_edge();
        @(negedge clk);
        chk("tx", 32'(tx), 32'(m_tx()));
        chk("irq", 32'(irq), 32'(!m_busy && (m_q.size() == 0)));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd_en = 1'b0;
    endtask

    initial begin
        m_reset();
        // Reset state
        tick();
        tick();
        rd_chk("rst_status", 4'h4, 32'h0000_0004);
        rd_chk("rst_div", 4'h8, 32'd4);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_chk("txdata_reads_zero", 4'h0, 32'd0);
        addr = 4'h8;
        #1;
        chk("rd_en_low_zero", rdata, 32'd0);

        // Single byte at divisor 4
        wr(4'h0, 32'h0000_00A5);
        rd_chk("single_status", 4'h4, m_status());
        for (int i = 0; i < 44; i++) tick();
        chk("single_irq_end", 32'(irq), 32'd1);

        // Fill and overflow, then clear
        for (int i = 0; i < 5; i++) wr(4'h0, 32'(8'h30 + i));
        rd_chk("fill_no_ovf", 4'h4, 32'h0000_0043);
        wr(4'h0, 32'h0000_00EE);
        rd_chk("ovf_status", 4'h4, 32'h0000_004B);
        wr(4'h4, 32'h0000_0008);
        rd_chk("ovf_cleared", 4'h4, 32'h0000_0043);
        for (int i = 0; i < 210; i++) tick();
        rd_chk("drained", 4'h4, 32'h0000_0004);

        // Back-to-back at divisor 1
        wr(4'h8, 32'd1);
        wr(4'h0, 32'h0000_0001);
        wr(4'h0, 32'h0000_00FF);
        wr(4'h0, 32'h0000_0000);
        for (int i = 0; i < 32; i++) tick();

        // Divisor change mid-frame
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h0000_005A);
        wr(4'h0, 32'h0000_00C3);
        for (int i = 0; i < 4; i++) tick();
        wr(4'h8, 32'd8);
        rd_chk("div8", 4'h8, 32'd8);
        for (int i = 0; i < 100; i++) tick();
        wr(4'h8, 32'd0);
        rd_chk("div0_as_1", 4'h8, 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15) wr(4'h0, 32'($urandom_range(0, 255)));
            else if (r < 18) wr(4'h8, 32'($urandom_range(0, 3)));
            else if (r < 21) wr(4'h4, 32'h0000_0008);
            else tick();
            rd_chk("rand_status", 4'h4, m_status());
            if (r < 18) rd_chk("rand_div", 4'h8, 32'(m_div));
        end
        for (int i = 0; i < 400 && (m_busy || m_q.size() > 0); i++) tick();
        chk("rand_drained", 32'(m_busy || m_q.size() > 0), 32'd0);

        // Reset mid-frame with two bytes queued
        wr(4'h8, 32'd4);
        wr(4'h0, 32'h0000_0000);
        wr(4'h0, 32'h0000_0011);
        wr(4'h0, 32'h0000_0022);
        for (int i = 0; i < 16; i++) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        rd_chk("rst_mid_status", 4'h4, 32'h0000_0004);
        m_reset();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_idle", 32'(tx), 32'd1);
        end
        rd_chk("post_rst_div", 4'h8, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: TX FIFO entries, a power of two from 2 to 16.
REQ-002 SHALL have parameter DIV_RESET, default 16'd4: clocks per bit after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port addr, input, 4 bits: byte address from the core load/store path; only bits [3:2] are decoded.
REQ-006 SHALL have port wdata, input, 32 bits: store data.
REQ-007 SHALL have port wr_en, input, 1 bit: store strobe, sampled at the rising edge.
REQ-008 SHALL have port rd_en, input, 1 bit: load strobe.
REQ-009 SHALL have port rdata, output, 32 bits: load data, combinational from addr.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port irq, output, 1 bit: level, high when the FIFO is empty and the FSM is IDLE, registered.

Function
REQ-012 SHALL decode this register map:
- 0x0 TXDATA (write-only): a write pushes wdata[7:0].
- 0x4 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] count.
- 0x8 DIVISOR: bits[15:0] RW.
- 0xC: reads 0, writes ignored.
REQ-013 SHALL return 0 on rdata for reads of TXDATA, and return 0 on all of rdata when rd_en is low.
REQ-014 SHALL drop a TXDATA write while the FIFO is full (FIFO unchanged) and set overflow.
REQ-015 SHALL clear overflow on a STATUS write with wdata[3]=1; a set and a clear in the same cycle leave it set.
REQ-016 SHALL store a DIVISOR write of 0 as 1.
REQ-017 SHALL latch DIVISOR into an internal bit period only at frame start; a write mid-frame affects only later frames.
REQ-018 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> (IDLE, or START if the FIFO is non-empty).
REQ-019 SHALL use these state actions:
- START drives tx=0.
- DATA shifts out 8 bits, LSB first.
- STOP drives tx=1.
- Each bit lasts exactly bit-period clocks.
REQ-020 SHALL pop the FIFO head on the edge that enters START, from IDLE or from STOP.
REQ-021 SHALL start the frame of a byte pushed at edge N into an empty FIFO with FSM IDLE on edge N+1: tx=0 from N+1.
REQ-022 SHALL send back-to-back frames with no idle gap: STOP of 1 bit, then START immediately.
REQ-023 SHALL make a pop and a push in the same cycle leave count unchanged and accept the push even when full.
REQ-024 SHALL maintain FIFO pointers that wrap modulo FIFO_DEPTH, with count 0..FIFO_DEPTH.
REQ-025 SHALL make frame length exactly 10 x bit-period clocks.
REQ-026 SHALL ignore wr_en and rd_en both high: the write takes effect and rdata is valid.

Reset
REQ-027 SHALL, while rst=0, force these values asynchronously:
- tx=1, irq=1, FSM IDLE.
- FIFO empty, count 0, overflow 0.
- DIVISOR=DIV_RESET, bit counters 0.
REQ-028 SHALL abort a frame when reset is asserted mid-frame: tx=1 immediately, the queued bytes are discarded, and no partial frame resumes after release.
REQ-029 SHALL start no frame on the first edge after rst deasserts unless a push occurs on that edge.

Verification
REQ-030 SHALL cover single byte: DIVISOR=4, write 0xA5 at edge N -> tx = 0 for cycles N+1..N+4, then the bits 1,0,1,0,0,1,0,1 for 4 clocks each, then 1 for 4 clocks. busy=1 throughout, then irq=1 at N+41.
REQ-031 SHALL cover fill/overflow: 5 writes in 5 consecutive cycles with DIVISOR=4 -> first byte popped and 4 queued, so none are dropped and overflow=0. A 6th write while count=4 and no pop -> dropped, overflow=1, and STATUS reads 0x4A|busy, i.e. count 4, full and overflow set.
REQ-032 SHALL cover back-to-back: 3 bytes, DIVISOR=1 -> 30 contiguous bit cycles with no idle high between the frames, then irq rises.
REQ-033 SHALL cover divisor change: write DIVISOR=8 during frame 1 at DIVISOR=2 -> frame 1 is 20 clocks and frame 2 is 80 clocks. A DIVISOR write of 0 reads back 1.
REQ-034 SHALL cover reset mid-frame: assert rst low at bit 3 with 2 bytes queued -> tx=1 and STATUS=0x04 with no clock edge. After release, tx stays 1 for 20 cycles.
REQ-035 SHALL cover overflow clear: with overflow=1, a STATUS write of 0x8 -> bit3=0 on the next read. The same write coincident with a dropped push -> bit3 stays 1.
